// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one combinational ALU between two requesters
// Optional per-requester completed-op counters: `ALU_SCHED_CNT_EN
module alu_rr_scheduler #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic [3:0]       i_req0_op,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic [3:0]       i_req1_op,
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [WIDTH-1:0] o_rsp0_data,
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [WIDTH-1:0] o_rsp1_data,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic             o_alu_logic_sel,
    output logic [2:0]       o_alu_sel,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic             o_busy,
    output logic             o_grant_id
`ifdef ALU_SCHED_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1
`endif
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic               r_alu_logic_sel;
    logic [2:0]         r_alu_sel;
    logic               r_grant_id;
    logic               r_pri;
    logic [SCW-1:0]     r_settle_cnt;
    logic [WIDTH-1:0]   r_rsp_data;

    logic               w_any_valid;
    logic               w_grant;
    logic               w_accept;
    logic               w_settled;
    logic               w_rsp_hs;
    logic               w_rsp_hs0;
    logic               w_rsp_hs1;

    // A single valid requester wins outright; PRI only breaks ties.
    assign w_any_valid = i_req0_valid | i_req1_valid;
    assign w_grant     = (i_req0_valid & i_req1_valid) ? r_pri : i_req1_valid;
    assign w_accept    = (r_state == ST_IDLE) & w_any_valid;
    assign w_settled   = (r_settle_cnt == SCW'(SETTLE_CYC - 1));

    assign w_rsp_hs0   = (r_state == ST_RESP) & ~r_grant_id & i_rsp0_ready;
    assign w_rsp_hs1   = (r_state == ST_RESP) &  r_grant_id & i_rsp1_ready;
    assign w_rsp_hs    = w_rsp_hs0 | w_rsp_hs1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)  w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_settled) w_state_nxt = ST_RESP;
            ST_RESP:  if (w_rsp_hs)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_logic_sel <= 1'b0;
            r_alu_sel       <= 3'd0;
            r_grant_id      <= 1'b0;
            r_pri           <= 1'b0;
            r_settle_cnt    <= '0;
            r_rsp_data      <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a         <= w_grant ? i_req1_a : i_req0_a;
                r_alu_b         <= w_grant ? i_req1_b : i_req0_b;
                r_alu_logic_sel <= w_grant ? i_req1_op[3] : i_req0_op[3];
                r_alu_sel       <= w_grant ? i_req1_op[2:0] : i_req0_op[2:0];
                r_grant_id      <= w_grant;
                r_pri           <= ~w_grant;
                r_settle_cnt    <= '0;
            end
            if (r_state == ST_ISSUE) begin
                r_settle_cnt <= r_settle_cnt + SCW'(1);
                if (w_settled) begin
                    r_rsp_data <= i_alu_result;
                end
            end
        end
    end

    // READY is gated by reset so every output reads 0 while reset is asserted.
    assign o_req0_ready    = i_rst_n & w_accept & ~w_grant;
    assign o_req1_ready    = i_rst_n & w_accept &  w_grant;
    assign o_rsp0_valid    = (r_state == ST_RESP) & ~r_grant_id;
    assign o_rsp1_valid    = (r_state == ST_RESP) &  r_grant_id;
    assign o_rsp0_data     = r_rsp_data;
    assign o_rsp1_data     = r_rsp_data;
    assign o_alu_a         = r_alu_a;
    assign o_alu_b         = r_alu_b;
    assign o_alu_logic_sel = r_alu_logic_sel;
    assign o_alu_sel       = r_alu_sel;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_grant_id      = r_grant_id;

`ifdef ALU_SCHED_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_rsp_hs0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_rsp_hs1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign o_cnt0 = r_cnt0;
    assign o_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - directed table-driven bench for alu_rr_scheduler
module tb_alu_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result;
    logic       alu_logic_sel, busy, grant_id;
    logic [2:0] alu_sel;
`ifdef ALU_SCHED_CNT_EN
    logic [1:0] cnt0, cnt1;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic ls, input logic [2:0] s,
                                             input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = a * b;
        if (!ls) begin
            case (s)
                3'd0:    return a + b;
                3'd1:    return a - b;
                3'd2:    return p[7:0];
                default: return 8'h00;
            endcase
        end else begin
            case (s)
                3'd0:    return a & b;
                3'd1:    return a | b;
                3'd2:    return a ^ b;
                default: return ~a;
            endcase
        end
    endfunction

    assign alu_result = alu_model(alu_logic_sel, alu_sel, alu_a, alu_b);

    alu_rr_scheduler #(
        .WIDTH(8),
        .SETTLE_CYC(1),
        .CNT_W(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_op(req0_op),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_op(req1_op),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data),
        .o_alu_a(alu_a), .o_alu_b(alu_b),
        .o_alu_logic_sel(alu_logic_sel), .o_alu_sel(alu_sel),
        .i_alu_result(alu_result),
        .o_busy(busy), .o_grant_id(grant_id)
`ifdef ALU_SCHED_CNT_EN
        , .o_cnt0(cnt0), .o_cnt1(cnt1)
`endif
    );

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(input logic id, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] op);
        if (!id) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    task automatic do_op(input logic id, input logic [3:0] op);
        set_req(id, 1'b1, 8'h01, 8'h02, op);
        tick();
        set_req(id, 1'b0, 8'h01, 8'h02, op);
        tick();
        if (!id) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h37, 8'h32, 4'b0000, 8'h69};
        vecs[1] = '{1'b1, 8'h37, 8'h32, 4'b0001, 8'h05};
        vecs[2] = '{1'b0, 8'h37, 8'h32, 4'b1000, 8'h32};
        vecs[3] = '{1'b0, 8'h37, 8'h32, 4'b1001, 8'h37};
        vecs[4] = '{1'b1, 8'hff, 8'h01, 4'b0000, 8'h00};
        vecs[5] = '{1'b1, 8'h10, 8'h10, 4'b0010, 8'h00};
        vecs[6] = '{1'b0, 8'h0f, 8'hf0, 4'b1010, 8'hff};
        vecs[7] = '{1'b1, 8'h00, 8'h01, 4'b0001, 8'hff};

        // reset state
        tick();
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        rst_n = 1'b1;
        tick();

        // valid dropped without handshake
        set_req(1'b0, 1'b1, 8'h11, 8'h22, 4'b0000);
        #1 check("drop_rdy", req0_ready, 1);
        set_req(1'b0, 1'b0, 8'h11, 8'h22, 4'b0000);
        tick();
        check("drop_busy", busy, 0);

        foreach (vecs[i]) begin
            set_req(vecs[i].id, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            #1;
            check($sformatf("v%0d_rdy", i), vecs[i].id ? req1_ready : req0_ready, 1);
            check($sformatf("v%0d_rdy_other", i), vecs[i].id ? req0_ready : req1_ready, 0);
            tick();
            set_req(vecs[i].id, 1'b0, 8'h00, 8'h00, 4'h0);
            check($sformatf("v%0d_busy", i), busy, 1);
            check($sformatf("v%0d_grant", i), grant_id, vecs[i].id);
            check($sformatf("v%0d_alu", i), {alu_logic_sel, alu_sel, alu_a, alu_b},
                  {vecs[i].op, vecs[i].a, vecs[i].b});
            tick();
            check($sformatf("v%0d_rsp_valid", i), {rsp1_valid, rsp0_valid},
                  vecs[i].id ? 2'b10 : 2'b01);
            check($sformatf("v%0d_data", i), vecs[i].id ? rsp1_data : rsp0_data, vecs[i].exp);
            if (vecs[i].id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            tick();
            rsp0_ready = 1'b0; rsp1_ready = 1'b0;
            check($sformatf("v%0d_idle", i), busy, 0);
            check($sformatf("v%0d_alu_hold", i), {alu_a, alu_b}, {vecs[i].a, vecs[i].b});
        end

        // both valid right after reset: req0 first, then req1
        rst_n = 1'b0; #1 rst_n = 1'b1;
        set_req(1'b0, 1'b1, 8'h37, 8'h32, 4'b0001);
        set_req(1'b1, 1'b1, 8'h37, 8'h32, 4'b1001);
        #1;
        check("both_rdy", {req1_ready, req0_ready}, 2'b01);
        tick();
        set_req(1'b0, 1'b0, 8'h37, 8'h32, 4'b0001);
        check("both_grant0", grant_id, 0);
        check("both_rdy1_busy", req1_ready, 0);
        tick();
        check("both_data0", rsp0_data, 8'h05);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("both_rdy1", req1_ready, 1);
        tick();
        set_req(1'b1, 1'b0, 8'h37, 8'h32, 4'b1001);
        check("both_grant1", grant_id, 1);
        tick();
        check("both_data1", {rsp1_valid, rsp1_data}, {1'b1, 8'h37});
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        // continuous contention alternates grants
        set_req(1'b0, 1'b1, 8'h01, 8'h01, 4'b0000);
        set_req(1'b1, 1'b1, 8'h02, 8'h02, 4'b0000);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), grant_id, k % 2);
            tick();
            tick();
        end
        set_req(1'b0, 1'b0, 8'h01, 8'h01, 4'b0000);
        set_req(1'b1, 1'b0, 8'h02, 8'h02, 4'b0000);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // response stall on req1; wrong-id RSP_READY and new requests ignored
        set_req(1'b1, 1'b1, 8'h37, 8'h32, 4'b0000);
        tick();
        set_req(1'b1, 1'b0, 8'h37, 8'h32, 4'b0000);
        tick();
        set_req(1'b0, 1'b1, 8'h05, 8'h06, 4'b0000);
        rsp0_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_rsp", k), {rsp1_valid, rsp1_data, busy}, {1'b1, 8'h69, 1'b1});
            check($sformatf("stall%0d_rdy", k), {req1_ready, req0_ready}, 2'b00);
            tick();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        set_req(1'b0, 1'b0, 8'h05, 8'h06, 4'b0000);
        check("stall_release", {busy, rsp1_valid}, 2'b00);

        // asynchronous reset during ISSUE
        set_req(1'b0, 1'b1, 8'haa, 8'h55, 4'b1001);
        tick();
        set_req(1'b0, 1'b0, 8'haa, 8'h55, 4'b1001);
        set_req(1'b1, 1'b1, 8'h37, 8'h32, 4'b1000);
        check("mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_outs", {busy, grant_id, alu_a, alu_b, alu_logic_sel, alu_sel},
              {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
        check("arst_rdy", {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 4'b0000);
        tick();
        rst_n = 1'b1;
        #1 check("post_rst_rdy1", req1_ready, 1);
        tick();
        set_req(1'b1, 1'b0, 8'h37, 8'h32, 4'b1000);
        tick();
        check("post_rst_data", {rsp1_valid, rsp1_data}, {1'b1, 8'h32});
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

`ifdef ALU_SCHED_CNT_EN
        rst_n = 1'b0; #1 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) do_op(1'b0, 4'b0000);
        for (int k = 0; k < 2; k++) do_op(1'b1, 4'b0000);
        check("cnt0", cnt0, 3);
        check("cnt1", cnt1, 2);
        for (int k = 0; k < 2; k++) do_op(1'b0, 4'b0000);
        check("cnt0_sat", cnt0, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
